// File: rtl/sb_pkg.sv
// Shared types and width helpers for the sideband deserializer and its word FIFO.
// Counter widths are clamped to at least one bit so degenerate parameters stay legal.
package sb_pkg;

    typedef enum logic {
        RECV = 1'b0,
        GAP  = 1'b1
    } sb_state_e;

    localparam int SB_WORD_W  = 64;
    localparam int SB_MIN_GAP = 32;

    function automatic int bit_cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

    function automatic int gap_cnt_w(input int min_gap);
        return (min_gap > 0) ? $clog2(min_gap + 1) : 1;
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sb_word_fifo.sv
// DEPTH-entry word FIFO with registered head, no fall-through, and a drop strobe
// for a push that finds the FIFO full without a same-cycle pop.
module sb_word_fifo
    import sb_pkg::*;
#(
    parameter int WIDTH = SB_WORD_W,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         dropped
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign dropped   = push && full && !do_pop;
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];
    assign count     = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sb_deserializer_fifo.sv
// Sideband serial-to-parallel receiver: qualified bit capture, post-word idle-gap
// enforcement, sticky overflow/gap error flags, and a buffered ready/valid output.
module sb_deserializer_fifo
    import sb_pkg::*;
#(
    parameter int WIDTH     = SB_WORD_W,
    parameter int DEPTH     = 2,
    parameter int MIN_GAP   = SB_MIN_GAP,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         in_data,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level,
    output logic                         overflow,
    output logic                         gap_err,
    input  logic                         clear_err
);

    localparam int BIT_W    = bit_cnt_w(WIDTH);
    localparam int GAP_W    = gap_cnt_w(MIN_GAP);
    localparam int GAP_LAST = (MIN_GAP > 0) ? MIN_GAP - 1 : 0;

    sb_state_e        state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             overflow_q, overflow_d;
    logic             gap_err_q, gap_err_d;
    logic [BIT_W-1:0] bit_idx;
    logic             push;
    logic [WIDTH-1:0] push_word;
    logic             gap_hit;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_dropped;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        word_d    = word_q;
        push      = 1'b0;
        push_word = word_q;
        gap_hit   = 1'b0;
        bit_idx   = MSB_FIRST ? (BIT_W'(WIDTH - 1) - bit_cnt_q) : bit_cnt_q;

        case (state_q)
            RECV: begin
                if (in_valid) begin
                    word_d[bit_idx] = in_data;
                    if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
                        push      = 1'b1;
                        push_word = word_d;
                        bit_cnt_d = '0;
                        if (MIN_GAP > 0) begin
                            state_d = GAP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            GAP: begin
                // A stray bit restarts the idle window and is not captured.
                if (in_valid) begin
                    gap_hit   = 1'b1;
                    gap_cnt_d = '0;
                end else if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
                    gap_cnt_d = '0;
                    state_d   = RECV;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
        endcase

        overflow_d = fifo_dropped | (overflow_q & ~clear_err);
        gap_err_d  = gap_hit | (gap_err_q & ~clear_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RECV;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            word_q     <= '0;
            overflow_q <= 1'b0;
            gap_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            word_q     <= word_d;
            overflow_q <= overflow_d;
            gap_err_q  <= gap_err_d;
        end
    end

    sb_word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_word),
        .pop       (out_valid && out_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (out_data),
        .count     (fill_level),
        .dropped   (fifo_dropped)
    );

    assign out_valid = !fifo_empty;
    assign overflow  = overflow_q;
    assign gap_err   = gap_err_q;

endmodule

// File: tb/tb_sb_deserializer_fifo.sv
// Bench for sb_deserializer_fifo: a transaction-level model feeds a scoreboard queue,
// and a negedge monitor checks both bit-order variants against it.
module tb_sb_deserializer_fifo;

    localparam int W  = 8;
    localparam int D  = 2;
    localparam int MG = 4;

    logic clk = 1'b0;
    logic rst, in_valid, in_data, out_ready, clear_err;

    logic         a_out_valid, a_ovf, a_gerr;
    logic [W-1:0] a_out_data;
    logic [1:0]   a_fill;
    logic         b_out_valid, b_ovf, b_gerr;
    logic [W-1:0] b_out_data;
    logic [1:0]   b_fill;

    always #5 clk = ~clk;

    sb_deserializer_fifo #(.WIDTH(W), .DEPTH(D), .MIN_GAP(MG), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .out_ready(out_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .fill_level(a_fill),
        .overflow(a_ovf), .gap_err(a_gerr), .clear_err(clear_err));

    sb_deserializer_fifo #(.WIDTH(W), .DEPTH(D), .MIN_GAP(MG), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .out_ready(out_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .fill_level(b_fill),
        .overflow(b_ovf), .gap_err(b_gerr), .clear_err(clear_err));

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    // Reference model state
    logic         bits[$];
    logic [W-1:0] exp_q[$];
    int           gap_left = 0;
    int           m_cnt = 0;
    logic         m_ovf = 1'b0;
    logic         m_gerr = 1'b0;
    logic [W-1:0] last_a, last_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rev(input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = x[W-1-i];
        return r;
    endfunction

    always @(posedge clk) begin
        logic         pop, push, set_o, set_g;
        logic [W-1:0] w;
        if (rst) begin
            bits.delete();
            exp_q.delete();
            gap_left = 0;
            m_cnt    = 0;
            m_ovf    = 1'b0;
            m_gerr   = 1'b0;
        end else begin
            pop   = (m_cnt > 0) && out_ready;
            push  = 1'b0;
            set_o = 1'b0;
            set_g = 1'b0;
            if (gap_left > 0) begin
                if (in_valid) begin
                    set_g    = 1'b1;
                    gap_left = MG;
                end else begin
                    gap_left--;
                end
            end else if (in_valid) begin
                bits.push_back(in_data);
                if (bits.size() == W) begin
                    for (int i = 0; i < W; i++) w[i] = bits[i];
                    bits.delete();
                    gap_left = MG;
                    if (m_cnt == D && !pop) set_o = 1'b1;
                    else begin
                        exp_q.push_back(w);
                        push = 1'b1;
                    end
                end
            end
            m_cnt  = m_cnt + int'(push) - int'(pop);
            m_ovf  = set_o ? 1'b1 : (clear_err ? 1'b0 : m_ovf);
            m_gerr = set_g ? 1'b1 : (clear_err ? 1'b0 : m_gerr);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("fill_level", a_fill, m_cnt);
            check("out_valid", a_out_valid, m_cnt > 0);
            check("out_valid_msb", b_out_valid, m_cnt > 0);
            check("overflow", a_ovf, m_ovf);
            check("gap_err", a_gerr, m_gerr);
            check("overflow_msb", b_ovf, m_ovf);
            if (a_out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: actual=%0h expected=none at %0t", a_out_data, $time);
                end else begin
                    check("out_data", a_out_data, exp_q[0]);
                    check("out_data_msb", b_out_data, rev(exp_q[0]));
                    if (out_ready) begin
                        last_a = a_out_data;
                        last_b = b_out_data;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) drive(1'b1, w[i]);
    endtask

    initial begin
        logic [W-1:0] w;
        rst = 1'b1; in_valid = 1'b0; in_data = 1'b0; out_ready = 1'b1; clear_err = 1'b0;
        drive(1'b0, 1'b0);
        started = 1'b1;
        drive(1'b0, 1'b0);
        check("rst_out_valid", a_out_valid, 1'b0);
        check("rst_out_data", a_out_data, 8'h00);
        check("rst_fill", a_fill, 2'd0);
        check("rst_flags", {a_ovf, a_gerr}, 2'b00);
        rst = 1'b0;
        idle(2);

        // Basic word, both bit orders, one-cycle latency
        send_word(8'h4D);
        check("t1_latency_valid", a_out_valid, 1'b1);
        check("t1_word_lsb", a_out_data, 8'h4D);
        check("t1_word_msb", b_out_data, 8'hB2);
        idle(MG);

        // Paused capture
        w = 8'h4D;
        for (int i = 0; i < 4; i++) drive(1'b1, w[i]);
        idle(3);
        for (int i = 4; i < 8; i++) drive(1'b1, w[i]);
        check("t2_word", a_out_data, 8'h4D);
        idle(MG);
        check("t2_flags", {a_ovf, a_gerr}, 2'b00);

        // Gap violation
        send_word(8'h3C);
        idle(1);
        drive(1'b1, 1'b1);
        check("t3_gap_err_set", a_gerr, 1'b1);
        idle(MG);
        send_word(8'hFF);
        check("t3_word_ff", a_out_data, 8'hFF);
        idle(MG);
        clear_err = 1'b1;
        drive(1'b0, 1'b0);
        clear_err = 1'b0;
        check("t3_gap_err_clear", a_gerr, 1'b0);

        // Overflow
        out_ready = 1'b0;
        send_word(8'h01); idle(MG);
        send_word(8'h02); idle(MG);
        send_word(8'h03);
        check("t4_fill_full", a_fill, 2'd2);
        check("t4_overflow", a_ovf, 1'b1);
        check("t4_head", a_out_data, 8'h01);
        idle(MG);
        out_ready = 1'b1;
        drive(1'b0, 1'b0);
        check("t4_second", a_out_data, 8'h02);
        drive(1'b0, 1'b0);
        check("t4_drained", a_out_valid, 1'b0);
        check("t4_last_popped", last_a, 8'h02);
        clear_err = 1'b1;
        drive(1'b0, 1'b0);
        clear_err = 1'b0;

        // Push and pop on the same edge while full
        out_ready = 1'b0;
        send_word(8'h21); idle(MG);
        send_word(8'h22); idle(MG);
        w = 8'h23;
        for (int i = 0; i < 7; i++) drive(1'b1, w[i]);
        out_ready = 1'b1;
        drive(1'b1, w[7]);
        check("t5_fill_kept", a_fill, 2'd2);
        check("t5_no_overflow", a_ovf, 1'b0);
        check("t5_order_head", a_out_data, 8'h22);
        idle(1);
        check("t5_order_tail", a_out_data, 8'h23);
        idle(MG - 1);
        check("t5_last_popped", last_a, 8'h23);

        // Reset mid-word
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
        rst = 1'b1;
        drive(1'b0, 1'b0);
        rst = 1'b0;
        send_word(8'hA5);
        check("t6_word_a5", a_out_data, 8'hA5);
        check("t6_word_a5_msb", b_out_data, 8'hA5);
        idle(MG);

        // Overflow set and clear_err in the same cycle
        out_ready = 1'b0;
        send_word(8'h11); idle(MG);
        send_word(8'h12); idle(MG);
        w = 8'h13;
        for (int i = 0; i < 7; i++) drive(1'b1, w[i]);
        clear_err = 1'b1;
        drive(1'b1, w[7]);
        clear_err = 1'b0;
        check("t6_set_wins", a_ovf, 1'b1);
        out_ready = 1'b1;
        idle(MG);
        clear_err = 1'b1;
        drive(1'b0, 1'b0);
        clear_err = 1'b0;

        // Randomized bursts
        for (int b = 0; b < 400; b++) begin
            int kind;
            kind      = $urandom_range(0, 9);
            out_ready = ($urandom_range(0, 2) != 0);
            clear_err = ($urandom_range(0, 15) == 0);
            if (kind < 5) begin
                send_word(W'($urandom));
            end else if (kind < 8) begin
                idle($urandom_range(0, 6));
            end else if (kind == 8) begin
                drive(1'b1, 1'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                drive(1'b0, 1'b0);
                rst = 1'b0;
            end else begin
                for (int i = 0; i < 3; i++) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            clear_err = 1'b0;
        end

        out_ready = 1'b1;
        idle(10);
        check("final_scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
